// File: rtl/axis_power_pkg.sv
// Shared types and arithmetic helpers for the power-detector datapath.
// sat_round is written width-generic so the accumulator block can reuse it.
package axis_power_pkg;

  typedef enum logic {
    MODE_REAL = 1'b0,
    MODE_IQ   = 1'b1
  } mode_t;

  localparam int unsigned MAX_W = 32;

  function automatic int unsigned shift_w(input int unsigned w);
    return $clog2(2 * w + 2);
  endfunction

  // Shift an already-rounded non-negative sum, then clamp to the signed W-bit max.
  // Returns {sat, value}; out-of-range shifts (> 2w) yield zero.
  function automatic logic [MAX_W:0] sat_round(input logic [2*MAX_W:0] s,
                                               input int unsigned       shift,
                                               input int unsigned       w);
    logic [2*MAX_W:0] r;
    logic [2*MAX_W:0] lim;
    r   = (shift > 2 * w) ? '0 : (s >> shift);
    lim = ((2*MAX_W+1)'(1) << (w - 1)) - (2*MAX_W+1)'(1);
    if (r > lim) return {1'b1, MAX_W'(lim)};
    else         return {1'b0, MAX_W'(r)};
  endfunction

endpackage

// File: rtl/axis_power_if.sv
// Minimal AXI-stream bundle: valid/ready/data with master and slave views.
interface Axis_If #(
  parameter int unsigned DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport Slave_Simple  (input valid, input data, output ready);
  modport Master_Simple (output valid, output data, input ready);
endinterface

// File: rtl/axis_power_lane.sv
// S1-S3 datapath for one lane pair (or a lone final lane): square, IQ combine
// with rounding, then shift/saturate into the output register.
module axis_power_lane
  import axis_power_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned LANES   = 2,
  parameter int unsigned SHIFT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [LANES*W-1:0]   x,
  input  mode_t                mode,
  input  logic [SHIFT_W-1:0]   shift_s1,
  input  logic [SHIFT_W-1:0]   shift_s2,
  output logic [LANES*W-1:0]   y,
  output logic                 sat
);

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(2 * W);

  logic [LANES-1:0][2*W-1:0] prod_d, prod_q;
  logic [LANES-1:0][2*W:0]   s_d, s_q;
  logic [LANES-1:0][W-1:0]   y_d, y_q;
  logic [LANES-1:0]          lane_sat;
  logic signed [2*W-1:0]     xe;
  logic [2*W:0]              rnd;
  logic [MAX_W:0]            res;

  always_comb begin
    prod_d = '0;
    xe     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      xe        = {{W{x[i*W+W-1]}}, x[i*W +: W]};
      prod_d[i] = xe * xe;
    end
  end

  always_comb begin
    rnd = '0;
    if (shift_s1 != '0 && shift_s1 <= MAX_SHIFT)
      rnd = (2*W+1)'(1) << (shift_s1 - SHIFT_W'(1));
    s_d = '0;
    for (int unsigned i = 0; i < LANES; i++)
      s_d[i] = {1'b0, prod_q[i]} + rnd;
    // Upper index written as LANES-1 so a lone lane never elaborates an out-of-range select.
    if (LANES == 2 && mode == MODE_IQ) begin
      s_d[0]       = {1'b0, prod_q[0]} + {1'b0, prod_q[LANES-1]} + rnd;
      s_d[LANES-1] = rnd;
    end
  end

  always_comb begin
    y_d      = '0;
    lane_sat = '0;
    res      = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      res         = sat_round((2*MAX_W+1)'(s_q[i]), 32'(shift_s2), W);
      y_d[i]      = W'(res);
      lane_sat[i] = res[MAX_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      s_q    <= '0;
      y_q    <= '0;
    end else if (en) begin
      prod_q <= prod_d;
      s_q    <= s_d;
      y_q    <= y_d;
    end
  end

  assign y   = y_q;
  assign sat = |lane_sat;

endmodule

// File: rtl/axis_power.sv
// Streaming power detector: per-lane x^2 or pairwise I^2+Q^2 with runtime
// shift, round-half-up, saturation and a sticky saturation flag.
module axis_power
  import axis_power_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned PARALLEL_SAMPLES = 1,
  parameter int unsigned DEFAULT_SHIFT    = 16,
  localparam int unsigned SHIFT_W         = shift_w(SAMPLE_WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  Axis_If.Slave_Simple       data_in,
  Axis_If.Master_Simple      data_out,
  input  logic               mode,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               sat_clear,
  output logic               sat_flag
);

  localparam int unsigned W     = SAMPLE_WIDTH;
  localparam int unsigned P     = PARALLEL_SAMPLES;
  localparam int unsigned NPAIR = (P + 1) / 2;

  logic               en;
  logic               accept;
  logic [W*P-1:0]     x0_d, x0_q;
  logic [W*P-1:0]     y_all;
  mode_t              mode0_d, mode0_q, mode1_d, mode1_q;
  logic [SHIFT_W-1:0] shift0_d, shift0_q, shift1_d, shift1_q, shift2_d, shift2_q;
  logic [3:0]         vld_d, vld_q;   // S0, S1, S2, output register
  logic               sat_d, sat_q;
  logic [NPAIR-1:0]   pair_sat;

  assign en            = data_out.ready || !vld_q[3];
  assign accept        = data_in.valid && en;
  assign data_in.ready = en;

  always_comb begin
    x0_d     = data_in.data;
    mode0_d  = mode_t'(mode);
    shift0_d = shift;
    mode1_d  = mode0_q;
    shift1_d = shift0_q;
    shift2_d = shift1_q;
    vld_d    = {vld_q[2:0], accept};
    sat_d    = sat_q;
    if (sat_clear)
      sat_d = 1'b0;
    if (en && vld_q[2] && (|pair_sat))
      sat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q     <= '0;
      mode0_q  <= MODE_REAL;
      mode1_q  <= MODE_REAL;
      shift0_q <= SHIFT_W'(DEFAULT_SHIFT);
      shift1_q <= SHIFT_W'(DEFAULT_SHIFT);
      shift2_q <= SHIFT_W'(DEFAULT_SHIFT);
      vld_q    <= '0;
    end else if (en) begin
      x0_q     <= x0_d;
      mode0_q  <= mode0_d;
      mode1_q  <= mode1_d;
      shift0_q <= shift0_d;
      shift1_q <= shift1_d;
      shift2_q <= shift2_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_q <= 1'b0;
    else          sat_q <= sat_d;
  end

  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    localparam int unsigned LANES = (2 * k + 1 < P) ? 2 : 1;
    axis_power_lane #(
      .W       (W),
      .LANES   (LANES),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .x        (x0_q[2*k*W +: LANES*W]),
      .mode     (mode1_q),
      .shift_s1 (shift1_q),
      .shift_s2 (shift2_q),
      .y        (y_all[2*k*W +: LANES*W]),
      .sat      (pair_sat[k])
    );
  end

  assign data_out.valid = vld_q[3];
  assign data_out.data  = y_all;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_axis_power.sv
// Bench for axis_power (W=16, P=2): directed vector table, sat_flag and reset
// sequences, and a randomized backpressure stream against a reference model.
module tb_axis_power;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_r = 1'b0;
  logic [5:0] shift_r = 6'd16;
  logic       sat_clear = 1'b0;
  logic       sat_flag;

  Axis_If #(.DATA_W(32)) in_if ();
  Axis_If #(.DATA_W(32)) out_if ();

  axis_power #(
    .SAMPLE_WIDTH     (16),
    .PARALLEL_SAMPLES (2),
    .DEFAULT_SHIFT    (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (in_if),
    .data_out  (out_if),
    .mode      (mode_r),
    .shift     (shift_r),
    .sat_clear (sat_clear),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  localparam int N_BEATS = 48;

  typedef struct {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  typedef struct {
    logic        md;
    int unsigned sh;
    logic [15:0] x0, x1, e0, e1;
    logic        es;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ref_lane(input longint v, input int unsigned sh);
    longint vv;
    longint r;
    if (sh > 32) return 17'd0;
    vv = v;
    if (sh > 0) vv = vv + (longint'(1) << (sh - 1));
    r = vv >> sh;
    if (r > 32767) return {1'b1, 16'h7FFF};
    return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t ref_beat(input logic md, input int unsigned sh,
                                    input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa, sb;
    longint pa, pb;
    logic [16:0] l0, l1;
    exp_t e;
    sa = a; sb = b;
    pa = longint'(sa) * longint'(sa);
    pb = longint'(sb) * longint'(sb);
    if (md) begin
      l0 = ref_lane(pa + pb, sh);
      l1 = 17'd0;
    end else begin
      l0 = ref_lane(pa, sh);
      l1 = ref_lane(pb, sh);
    end
    e.data = {l1[15:0], l0[15:0]};
    e.sat  = l0[16] | l1[16];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
  endtask

  // Single beat into an idle pipeline; lat counts edges from the accepting one.
  task automatic send_one(input logic md, input int unsigned sh,
                          input logic [15:0] a, input logic [15:0] b, output int lat);
    mode_r       = md;
    shift_r      = 6'(sh);
    in_if.data   = {b, a};
    in_if.valid  = 1'b1;
    tick();
    in_if.valid  = 1'b0;
    lat = 1;
    while (!out_if.valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic driver();
    logic acc;
    for (int k = 0; k < N_BEATS; k++) begin
      if (k >= 32 && $urandom_range(0, 3) == 0) begin
        in_if.valid = 1'b0;
        tick();
      end
      if (k < 16) begin
        mode_r = 1'b0; shift_r = 6'd16;
        in_if.data = {16'(-(k * 1500)), 16'(k * 2000)};
      end else if (k < 32) begin
        mode_r = k[0]; shift_r = k[0] ? 6'd12 : 6'd16;
        in_if.data = $urandom;
      end else begin
        mode_r = 1'($urandom_range(0, 1));
        shift_r = 6'($urandom_range(0, 34));
        in_if.data = $urandom;
      end
      in_if.valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = in_if.ready;
        tick();
      end
      if (!acc) check("accept_timeout", 0, 1);
    end
    in_if.valid = 1'b0;
  endtask

  task automatic toggler();
    for (int c = 0; c < 300; c++) begin
      if (c >= 10 && c < 15) out_if.ready = 1'b0;
      else out_if.ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_if.ready = 1'b1;
  endtask

  task automatic monitor();
    exp_t q[$];
    exp_t e;
    logic prev_valid = 1'b0, prev_fire = 1'b0, model_flag = 1'b0;
    logic [31:0] held = '0;
    int got = 0;
    for (int c = 0; c < 2000 && got < N_BEATS; c++) begin
      @(negedge clk);
      if (in_if.valid && in_if.ready)
        q.push_back(ref_beat(mode_r, shift_r, in_if.data[15:0], in_if.data[31:16]));
      if (out_if.valid && (!prev_valid || prev_fire)) begin
        check("out_expected", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          model_flag = model_flag | q[0].sat;
          check("sat_flag_stream", sat_flag, model_flag);
        end
      end
      if (out_if.valid && prev_valid && !prev_fire)
        check("stall_hold", out_if.data, held);
      if (out_if.valid && !out_if.ready)
        check("in_ready_stall", in_if.ready, 0);
      if (out_if.valid && out_if.ready && q.size() > 0) begin
        e = q.pop_front();
        check("beat_data", out_if.data, e.data);
        got++;
      end
      held       = out_if.data;
      prev_valid = out_if.valid;
      prev_fire  = out_if.valid && out_if.ready;
    end
    check("all_beats", got, N_BEATS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;

    vecs[0] = '{md:1'b0, sh:16, x0:16'h4000, x1:16'hC000, e0:16'h1000, e1:16'h1000, es:1'b0};
    vecs[1] = '{md:1'b0, sh:16, x0:16'h8000, x1:16'h0000, e0:16'h4000, e1:16'h0000, es:1'b0};
    vecs[2] = '{md:1'b0, sh:14, x0:16'h8000, x1:16'h0000, e0:16'h7FFF, e1:16'h0000, es:1'b1};
    vecs[3] = '{md:1'b1, sh:12, x0:16'd3000, x1:16'd4000, e0:16'd6104, e1:16'h0000, es:1'b0};
    vecs[4] = '{md:1'b0, sh:0,  x0:16'd181,  x1:16'd182,  e0:16'd32761, e1:16'h7FFF, es:1'b1};
    vecs[5] = '{md:1'b0, sh:40, x0:16'h7FFF, x1:16'h8000, e0:16'h0000, e1:16'h0000, es:1'b0};
    vecs[6] = '{md:1'b1, sh:32, x0:16'h8000, x1:16'h8000, e0:16'h0001, e1:16'h0000, es:1'b0};
    vecs[7] = '{md:1'b1, sh:16, x0:16'h8000, x1:16'h8000, e0:16'h7FFF, e1:16'h0000, es:1'b1};
    vecs[8] = '{md:1'b0, sh:15, x0:16'h7FFF, x1:16'h0001, e0:16'd32766, e1:16'h0000, es:1'b0};
    vecs[9] = '{md:1'b0, sh:1,  x0:16'd3,    x1:16'hFFFD, e0:16'd5,     e1:16'd5,     es:1'b0};

    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_if.valid, 0);
    check("rst_data", out_if.data, 0);
    check("rst_sat", sat_flag, 0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      pulse_clear();
      send_one(vecs[i].md, vecs[i].sh, vecs[i].x0, vecs[i].x1, lat);
      check($sformatf("lat_v%0d", i), lat, 4);
      check($sformatf("lane0_v%0d", i), out_if.data[15:0], vecs[i].e0);
      check($sformatf("lane1_v%0d", i), out_if.data[31:16], vecs[i].e1);
      check($sformatf("sat_v%0d", i), sat_flag, vecs[i].es);
      tick();
    end

    pulse_clear();
    send_one(1'b0, 14, 16'h8000, 16'h0000, lat);
    check("sat_set", sat_flag, 1);
    pulse_clear();
    check("sat_cleared", sat_flag, 0);

    // Clear asserted on the very edge that loads a saturating beat.
    mode_r = 1'b0; shift_r = 6'd14; in_if.data = {16'h0000, 16'h8000};
    in_if.valid = 1'b1;
    tick();
    in_if.valid = 1'b0;
    tick();
    tick();
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    check("setclr_valid", out_if.valid, 1);
    check("setclr_flag", sat_flag, 1);
    pulse_clear();
    check("setclr_after", sat_flag, 0);

    repeat (4) tick();
    fork
      driver();
      toggler();
      monitor();
    join
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    repeat (6) tick();

    pulse_clear();
    mode_r = 1'b0; shift_r = 6'd14; in_if.data = {16'h8000, 16'h8000};
    in_if.valid = 1'b1;
    repeat (4) tick();
    in_if.valid = 1'b0;
    check("pre_rst_valid", out_if.valid, 1);
    check("pre_rst_sat", sat_flag, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_if.valid, 0);
    check("async_rst_sat", sat_flag, 0);
    check("async_rst_data", out_if.data, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | out_if.valid;
    end
    check("no_stale_beat", seen, 0);
    send_one(1'b0, 16, 16'h4000, 16'h4000, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_data", out_if.data, 32'h1000_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
